// File: rtl/cp0_pkg.sv
// Shared constants and field helpers for the CP0 register file.
// Register indices, SR/Cause bit positions and ExcCode values.
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam int SR_IE       = 0;
    localparam int SR_EXL      = 1;
    localparam int SR_IM_LO    = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_BD    = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                            input logic ie);
        logic [31:0] w;
        w = '0;
        w[SR_IM_LO +: 6] = im;
        w[SR_EXL]        = exl;
        w[SR_IE]         = ie;
        return w;
    endfunction

    function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                               input logic [4:0] code);
        logic [31:0] w;
        w = '0;
        w[CAUSE_BD]              = bd;
        w[CAUSE_IP_LO +: 6]      = ip;
        w[CAUSE_EXC_LO +: 5]     = code;
        return w;
    endfunction

endpackage

// File: rtl/cp0_int_arbiter.sv
// Combinational interrupt/exception arbitration for CP0.
// Interrupts win over synchronous exceptions; both are blocked while EXL is set.
module cp0_int_arbiter
    import cp0_pkg::*;
(
    input  logic [5:0] int_lines,
    input  logic [5:0] im,
    input  logic       ie,
    input  logic       exl,
    input  logic       exc_valid,
    input  logic [4:0] exc_code,
    output logic       int_req,
    output logic       take,
    output logic [4:0] take_code
);

    logic exc_req;

    assign int_req   = (|(int_lines & im)) & ie & ~exl;
    assign exc_req   = exc_valid & ~exl;
    assign take      = int_req | exc_req;
    assign take_code = int_req ? EXC_INT : exc_code;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file (SR, Cause, EPC, PRId) for the M stage of the MIPS pipeline.
// Define CP0_TIMER_EN to add Count (reg 9), Compare (reg 11) and the timer interrupt on hw_int[5].
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID       = 32'h4D49_5053,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  rd_addr,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        eret,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [5:0]  hw_int,
    output logic [31:0] rd_data,
    output logic [31:0] epc,
    output logic        exc_take,
    output logic [31:0] exc_pc
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [29:0] epc_q;

    logic [5:0]  int_lines;
    logic        int_req;
    logic [4:0]  take_code;
    logic        wr_ok;
    logic [29:0] epc_next;
    logic        unused_pc_bits;

    assign wr_ok          = wr_en & ~exc_take;
    assign epc_next       = pc_m[31:2] - {29'd0, bd_m};
    assign unused_pc_bits = ^pc_m[1:0];

`ifdef CP0_TIMER_EN
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        timer_pending;

    assign int_lines = hw_int | {timer_pending, 5'd0};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q       <= '0;
            compare_q     <= '0;
            timer_pending <= 1'b0;
        end else begin
            if (wr_ok && rd_addr == REG_COUNT) begin
                count_q <= wr_data;
            end else begin
                count_q <= count_q + 32'd1;
            end
            if (wr_ok && rd_addr == REG_COMPARE) begin
                compare_q     <= wr_data;
                timer_pending <= 1'b0;
            end else if (count_q == compare_q && compare_q != 32'd0) begin
                timer_pending <= 1'b1;
            end
        end
    end
`else
    assign int_lines = hw_int;
`endif

    cp0_int_arbiter u_arbiter (
        .int_lines (int_lines),
        .im        (sr_im),
        .ie        (sr_ie),
        .exl       (sr_exl),
        .exc_valid (exc_valid),
        .exc_code  (exc_code),
        .int_req   (int_req),
        .take      (exc_take),
        .take_code (take_code)
    );

    // A take always sets EXL; ERET clears it only when nothing is being taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_im  <= '0;
            sr_exl <= 1'b0;
            sr_ie  <= 1'b0;
        end else begin
            if (wr_ok && rd_addr == REG_SR) begin
                sr_im <= wr_data[SR_IM_LO +: 6];
                sr_ie <= wr_data[SR_IE];
            end
            if (exc_take) begin
                sr_exl <= 1'b1;
            end else if (eret) begin
                sr_exl <= 1'b0;
            end else if (wr_ok && rd_addr == REG_SR) begin
                sr_exl <= wr_data[SR_EXL];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
        end else begin
            cause_ip <= int_lines;
            if (exc_take) begin
                cause_bd  <= bd_m;
                cause_exc <= take_code;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            epc_q <= '0;
        end else if (exc_take) begin
            epc_q <= epc_next;
        end else if (wr_ok && rd_addr == REG_EPC) begin
            epc_q <= wr_data[31:2];
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            REG_SR:    rd_data = pack_sr(sr_im, sr_exl, sr_ie);
            REG_CAUSE: rd_data = pack_cause(cause_bd, cause_ip, cause_exc);
            REG_EPC:   rd_data = {epc_q, 2'b00};
            REG_PRID:  rd_data = PRID;
`ifdef CP0_TIMER_EN
            REG_COUNT:   rd_data = count_q;
            REG_COMPARE: rd_data = compare_q;
`endif
            default:   rd_data = '0;
        endcase
    end

    assign epc    = {epc_q, 2'b00};
    assign exc_pc = EXC_VECTOR;

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file for the 5-stage MIPS pipeline; sits in the M stage directly downstream of the CP0 instruction decoder.
- Consumes the decoder's write-enable and ERET strobe.
- Holds SR(12), Cause(13), EPC(14) and PRId(15).
- Arbitrates interrupts and exceptions, and presents the exception request and EPC to the PC/flush logic.

Parameters:
- PRID, 32'h4D49_5053, read-only value of PRId (reg 15).
- EXC_VECTOR, 32'h0000_4180, handler address driven on `exc_pc` while `exc_take` is high.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- rd_addr  in  5  CP0 register index for MFC0 read (Instr[15:11]).
- wr_en  in  1  MTC0 write enable (decoder CP0WE).
- wr_data  in  32  MTC0 source (GPR rt, forwarded).
- eret  in  1  ERET in M stage (decoder IsERET).
- pc_m  in  32  PC of the instruction in M.
- bd_m  in  1  M instruction is in a branch delay slot.
- exc_valid  in  1  synchronous exception raised by the M instruction.
- exc_code  in  5  ExcCode for that exception (4 AdEL, 5 AdES, 10 RI, 12 Ov).
- hw_int  in  6  external interrupt lines, level-sensitive, already synchronised.
- rd_data  out  32  combinational read of rd_addr.
- epc  out  32  current EPC register, for ERET redirect.
- exc_take  out  1  exception or interrupt accepted this cycle; flush F/D/E/M.
- exc_pc  out  32  EXC_VECTOR.

Behaviour:
- Reset (async, reset_n=0): SR, Cause, EPC = 0.
- Outputs at reset: exc_take=0, epc=0, rd_data reflects the zeroed registers.
- SR fields: IM[15:10], EXL[1], IE[0]. Other bits read 0 and are not writable.
- Cause fields: BD[31], IP[15:10], ExcCode[6:2]. Other bits read 0.
- Cause is not MTC0-writable; writes to Cause are ignored.
- IP sampling: IP <= hw_int every cycle, unconditionally, including the take cycle.
- int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL. Uses live hw_int and registered SR; zero-cycle latency.
- exc_req = exc_valid & ~SR.EXL.
- exc_take = int_req | exc_req (combinational).
- Priority: interrupt over exception. When both are raised, ExcCode = 0.
- On a clock edge with exc_take=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= int_req ? 0 : exc_code.
  - Cause.BD <= bd_m.
  - EPC <= bd_m ? pc_m-4 : pc_m, with bits [1:0] forced to 0.
  - Any simultaneous MTC0 is suppressed; the instruction is squashed.
- On an edge with eret=1 and exc_take=0: SR.EXL <= 0. No other state changes.
- eret together with exc_take: exc_take wins; EXL stays 1 and EPC is overwritten.
- On an edge with wr_en=1 and exc_take=0:
  - rd_addr 12: SR <= masked wr_data.
  - rd_addr 14: EPC <= {wr_data[31:2], 2'b00}.
  - Other addresses: ignored.
- Read path:
  - rd_data is combinational from the registers; no internal write-to-read bypass.
  - A same-cycle MTC0 is visible on the next cycle.
  - Unmapped addresses read 0.
  - rd_addr 15 reads PRID.
- The `epc` output is the register value; it updates the cycle after a write or take.
- Reset asserted mid-operation clears all state immediately, regardless of pending exc_take.

Optional Feature:
- Macro: CP0_TIMER_EN.
- When defined, adds Count (reg 9) and Compare (reg 11).
  - Both reset to 0; both are MTC0-writable.
  - Count increments by 1 every cycle and wraps at 2^32. An MTC0 to Count takes precedence over the increment.
  - A timer-pending flop sets when Count==Compare and Compare!=0.
  - The flop clears on an MTC0 to Compare.
  - The flop is ORed into hw_int[5] before sampling and before int_req.
- When undefined, regs 9 and 11 read 0, writes to them are ignored, and there is no timer logic.

Decomposition:
- Shared package cp0_pkg:
  - Register index constants (SR=12, CAUSE=13, EPC=14, PRID=15, COUNT=9, COMPARE=11).
  - Field bit positions.
  - ExcCode constants (INT=0, ADEL=4, ADES=5, RI=10, OV=12).
- One natural sub-module: cp0_int_arbiter, the combinational int_req/exc_req/priority logic.
- The register flops stay in cp0_regfile.

Test Plan:
- Reset, then read regs 12, 13, 14, 15 -> 0, 0, 0, 32'h4D495053. Then deassert reset_n mid-sequence -> all cleared asynchronously.
- MTC0 SR=32'h0000_FC01; set hw_int=6'b000100 -> exc_take=1 same cycle. Next cycle: ExcCode=0, EXL=1, EPC=pc_m, exc_take=0 while hw_int stays high.
- exc_valid=1, exc_code=12, bd_m=1, pc_m=32'h3008 -> EPC=32'h3004, BD=1, ExcCode=12.
- Same cycle: hw_int enabled and exc_valid=1 with code 10 -> ExcCode=0.
- Same cycle: MTC0 EPC=32'h1234 and exc_valid -> EPC=pc_m, not 32'h1234.
- ERET with EXL=1 -> EXL=0 next cycle. A then-pending enabled interrupt asserts exc_take in that following cycle.
- CP0_TIMER_EN: write Compare=5, Count=0 -> timer pending and (with IM[15]=1, IE=1) exc_take appear about 5 cycles later. Write Compare=5 again -> pending clears.
